grant_hold_ctrl: RTL and testbench

- Registered ownership stage that sits directly downstream of the combinational daisy-chain priority arbiter (ArbiterN).
- Samples the arbiter's one-hot grant, locks it as the bus owner, and holds it until the owner finishes, drops its request, or exceeds its maximum tenure.
- A forced one-cycle idle gap follows every release; the arbiter's priority result is then re-sampled.
- Gives the daisy-chain arbiter transaction-level ownership without modifying it.

---
 rtl/grant_hold_pkg.sv | 29 ++
 rtl/grant_hold_ctrl_hold_counter.sv | 30 +++
 rtl/grant_hold_ctrl.sv | 121 ++++++++++++
 tb/tb_grant_hold_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/grant_hold_pkg.sv
// Shared types and helpers for the grant ownership stage that follows the daisy-chain arbiter.
// Vectors are in [0:N-1] order with bit 0 as the highest-priority requester.
package grant_hold_pkg;

    localparam int MAX_N            = 32;
    localparam int MAX_IDX_W        = 5;
    localparam int DEFAULT_MAX_HOLD = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Callers zero-pad their [0:N-1] vector into the left end of a [0:MAX_N-1] vector.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [0:MAX_N-1] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) idx = MAX_IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [0:MAX_N-1] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/grant_hold_ctrl_hold_counter.sv
// Saturating tenure counter for the current bus owner.
// It flags expiry once the owner has held the bus for MAX_HOLD cycles.
module hold_counter #(
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/grant_hold_ctrl.sv
// Locks the arbiter's one-hot grant as bus owner until done, request drop or MAX_HOLD expiry.
// Optional macro GRANT_ONEHOT_CHECK_EN adds a sticky err output and a grant one-hot assertion.
module grant_hold_ctrl
    import grant_hold_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int MAX_HOLD = DEFAULT_MAX_HOLD,
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:N-1]     req,
    input  logic [0:N-1]     arb_gnt,
    input  logic [0:N-1]     done,
    output logic [0:N-1]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
`ifdef GRANT_ONEHOT_CHECK_EN
    ,
    output logic             err
`endif
);

    state_t           state, state_nxt;
    logic [0:N-1]     gnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             timeout_nxt;
    logic [0:MAX_N-1] arb_ext;
    logic             arb_ok;
    logic             expired;
    logic             own_done, own_drop, release_now;

    always_comb begin
        arb_ext          = '0;
        arb_ext[0:N-1]   = arb_gnt;
    end

    assign arb_ok      = is_onehot(arb_ext) && ((arb_gnt & req) != '0);
    assign own_done    = done[gnt_idx];
    assign own_drop    = !req[gnt_idx];
    assign release_now = own_done || own_drop || expired;

    hold_counter #(.MAX_HOLD(MAX_HOLD)) u_hold_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != OWNED),
        .enable  (state == OWNED),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        idx_nxt     = gnt_idx;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                idx_nxt = '0;
                if (arb_ok) begin
                    state_nxt = OWNED;
                    gnt_nxt   = arb_gnt;
                    idx_nxt   = IDX_W'(onehot_to_idx(arb_ext));
                end
            end
            OWNED: begin
                // arb_gnt is ignored here, so a higher-priority request never preempts the owner.
                if (release_now) begin
                    state_nxt   = RELEASE;
                    gnt_nxt     = '0;
                    idx_nxt     = '0;
                    timeout_nxt = expired && !own_done && !own_drop;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == OWNED);

`ifdef GRANT_ONEHOT_CHECK_EN
    logic [0:MAX_N-1] gnt_ext;

    always_comb begin
        gnt_ext        = '0;
        gnt_ext[0:N-1] = gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE && arb_gnt != '0
                     && (!is_onehot(arb_ext) || (arb_gnt & ~req) != '0)) begin
            err <= 1'b1;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt == '0) || is_onehot(gnt_ext));
`endif

endmodule

// File: tb/tb_grant_hold_ctrl.sv
// Directed scoreboard bench for grant_hold_ctrl with N=8, MAX_HOLD=4 and a behavioural priority arbiter.
// Stimulus pushes the hand-computed post-edge outputs; a monitor pops and compares after each edge.
module tb_grant_hold_ctrl;

    localparam int N        = 8;
    localparam int MAX_HOLD = 4;
    localparam int IDX_W    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [0:N-1]     req, done, arb_gnt, gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             busy, timeout;
`ifdef GRANT_ONEHOT_CHECK_EN
    logic             err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [0:N-1]     g;
        logic [IDX_W-1:0] i;
        logic             b;
        logic             t;
        string            nm;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Daisy-chain priority: lowest index with a request wins.
    always_comb begin
        arb_gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                arb_gnt    = '0;
                arb_gnt[k] = 1'b1;
            end
        end
    end

    grant_hold_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .arb_gnt (arb_gnt),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
`ifdef GRANT_ONEHOT_CHECK_EN
        ,
        .err     (err)
`endif
    );

    task automatic check(input string nm, input logic [0:N-1] eg, input logic [IDX_W-1:0] ei,
                         input logic eb, input logic et);
        checks++;
        if (gnt !== eg || gnt_idx !== ei || busy !== eb || timeout !== et) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%0d busy=%b timeout=%b, expected gnt=%b idx=%0d busy=%b timeout=%b",
                     nm, gnt, gnt_idx, busy, timeout, eg, ei, eb, et);
        end
    endtask

    task automatic step(input logic [0:N-1] r, input logic [0:N-1] d, input logic [0:N-1] eg,
                        input int ei, input logic et, input string nm);
        exp_t e;
        @(negedge clk);
        req   = r;
        done  = d;
        e.g   = eg;
        e.i   = IDX_W'(ei);
        e.b   = (eg != '0);
        e.t   = et;
        e.nm  = nm;
        sb.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.nm, e.g, e.i, e.b, e.t);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 8'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: timeout after 4 owned cycles, gap, re-grant.
        step(8'b10101010, 8'b0, 8'b10000000, 0, 1'b0, "s1_grant");
        step(8'b10101010, 8'b0, 8'b10000000, 0, 1'b0, "s1_hold1");
        step(8'b10101010, 8'b0, 8'b10000000, 0, 1'b0, "s1_hold2");
        step(8'b10101010, 8'b0, 8'b10000000, 0, 1'b0, "s1_hold3");
        step(8'b10101010, 8'b0, 8'b00000000, 0, 1'b1, "s1_timeout");
        step(8'b10101010, 8'b0, 8'b00000000, 0, 1'b0, "s1_gap");
        step(8'b10101010, 8'b0, 8'b10000000, 0, 1'b0, "s1_regrant");
        // Scenario 2: owner drops its request.
        step(8'b10101010, 8'b0, 8'b10000000, 0, 1'b0, "s2_hold");
        step(8'b00101010, 8'b0, 8'b00000000, 0, 1'b0, "s2_drop");
        step(8'b00101010, 8'b0, 8'b00000000, 0, 1'b0, "s2_gap");
        step(8'b00101010, 8'b0, 8'b00100000, 2, 1'b0, "s2_next");
        // Scenario 3: done in second owned cycle.
        step(8'b00101010, 8'b0,        8'b00100000, 2, 1'b0, "s3_hold");
        step(8'b00101010, 8'b00100000, 8'b00000000, 0, 1'b0, "s3_done");
        step(8'b00101010, 8'b0,        8'b00000000, 0, 1'b0, "s3_gap");
        step(8'b00101010, 8'b0,        8'b00100000, 2, 1'b0, "s3_regrant");
        // Scenario 4: no preemption by higher-priority requests.
        step(8'b00001010, 8'b0,        8'b00000000, 0, 1'b0, "s4_drop");
        step(8'b00001010, 8'b0,        8'b00000000, 0, 1'b0, "s4_gap");
        step(8'b00001010, 8'b0,        8'b00001000, 4, 1'b0, "s4_grant");
        step(8'b11111111, 8'b0,        8'b00001000, 4, 1'b0, "s4_nopreempt");
        step(8'b11111111, 8'b00001000, 8'b00000000, 0, 1'b0, "s4_done");
        step(8'b11111111, 8'b0,        8'b00000000, 0, 1'b0, "s4_gap2");
        step(8'b11111111, 8'b0,        8'b10000000, 0, 1'b0, "s4_top");
        // Scenario 5: done coincides with expiry, timeout stays low.
        step(8'b00001111, 8'b0,        8'b00000000, 0, 1'b0, "s5_drop");
        step(8'b00001111, 8'b0,        8'b00000000, 0, 1'b0, "s5_gap");
        step(8'b00001111, 8'b0,        8'b00001000, 4, 1'b0, "s5_grant");
        step(8'b00001111, 8'b0,        8'b00001000, 4, 1'b0, "s5_hold1");
        step(8'b00001111, 8'b0,        8'b00001000, 4, 1'b0, "s5_hold2");
        step(8'b00001111, 8'b0,        8'b00001000, 4, 1'b0, "s5_hold3");
        step(8'b00001111, 8'b00001000, 8'b00000000, 0, 1'b0, "s5_done_at_expiry");
        step(8'b00001111, 8'b0,        8'b00000000, 0, 1'b0, "s5_gap2");
        step(8'b00001111, 8'b0,        8'b00001000, 4, 1'b0, "s5_regrant");
        step(8'b00001111, 8'b0,        8'b00001000, 4, 1'b0, "s6_owned");
        // Scenario 6: asynchronous reset pulse between edges while owned.
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_reset", 8'b0, 3'd0, 1'b0, 1'b0);
        req = 8'b00001010;
        #1;
        rst_n = 1'b1;
        step(8'b00001010, 8'b0, 8'b00001000, 4, 1'b0, "s6_after_reset");
        step(8'b00001010, 8'b0, 8'b00001000, 4, 1'b0, "s6_hold1");
        step(8'b00001010, 8'b0, 8'b00001000, 4, 1'b0, "s6_hold2");
        step(8'b00001010, 8'b0, 8'b00001000, 4, 1'b0, "s6_hold3");
        step(8'b00001010, 8'b0, 8'b00000000, 0, 1'b1, "s6_timeout");
        step(8'b00001010, 8'b0, 8'b00000000, 0, 1'b0, "s6_gap");

        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
